module_light_ctrl: RTL
======================

// Module: module_light_ctrl
// PURPOSE
//   Runtime traffic-light controller for the main and sub roads; sits directly downstream of the init stage.
//   Loads the power-on phase and remaining time from the init_* ports, then counts seconds from a CLOCK_HZ prescaler.
//   Sequences main GREEN->YELLOW->RED and sub RED->GREEN->YELLOW, and drives the colour and display-time outputs to the display stage.
//   Supports pause (freeze) and online (all-flash) modes.
// PARAMETERS
//   CLOCK_HZ  5   clk cycles per 1 s tick
//   REDT      19  red duration, s (must equal GREENT+YELLOWT; max 31)
//   GREENT    16  green duration, s
//   YELLOWT   3   yellow duration, s
// PORTS
//   clk              in   1   single clock
//   rst              in   1   synchronous, active-high reset
//   init_main_state  in   3   phase loaded at reset/restart (state code)
//   init_sub_state   in   3   as above, sub road
//   init_main_rest   in   5   seconds remaining loaded at reset/restart
//   init_sub_rest    in   5   as above, sub road
//   power_en         in   1   0 = lights dark; controller held at init phase
//   pause            in   1   1 = freeze countdown and phase
//   online           in   1   1 = online (flash) mode
//   main_light_state out  3   REDS=0 GREENS=1 YELLOWS=2 ONLINES=3 PAUSES=4
//   sub_light_state  out  3   as above
//   main_rest_time   out  5   seconds remaining in current main phase
//   sub_rest_time    out  5   as above, sub road
//   MainTime,SubTime out 16   display value = zero-extended rest time
//   MainColor,SubColor out 8  lamp code REDL=1 GREENL=2 YELLOWL=3 ONLINEL=4; 0 = dark
// BEHAVIOUR
//   - Reset (rst=1 at edge): phases/rest <= init_* ports; prescaler <= 0; colours from init phase; times = init rest.
//     With the init stage attached: main GREENS/16/GREENL, sub REDS/19/REDL.
//   - Mode priority per cycle: rst > !power_en > online > pause > run.
//   - Prescaler: counts 0..CLOCK_HZ-1 in run mode only; tick = (cnt==CLOCK_HZ-1). First tick comes CLOCK_HZ clocks after reset release.
//   - Run, on tick, per road independently:
//     rest>1 -> rest-1.
//     rest==1 -> next phase, rest <= its duration (GREEN->YELLOW(YELLOWT)->RED(REDT)->GREEN(GREENT)).
//   - Outputs are registered and update in the same edge as the state change (1-cycle latency from tick).
//   - rest==0 on entry (bad init) is treated as rest==1: advances at the next tick.
//   - pause: prescaler, phase and rest hold. *_light_state = PAUSES; colours and times hold. On release, resume with no lost or extra cycle.
//   - online: both *_light_state = ONLINES, colours = ONLINEL, times = 0 (ONLINET).
//     On exit, reload init phase/rest, prescaler <= 0.
//   - !power_en: colours 0, times 0, states and rest reloaded from init ports each cycle. On re-enable, restart as after reset.
//   - rst mid-count or mid-mode: reset wins and applies in the same cycle; no residual prescaler count.
// CONFIGURATION
//   LIGHT_CTRL_BLINK_EN defined: in online mode colours alternate ONLINEL/0, toggling every CLOCK_HZ clocks (prescaler kept running).
//   Not defined: steady ONLINEL; prescaler held at 0 in online mode.
// STRUCTURE
//   light_pkg: state codes, lamp codes, REDT/GREENT/YELLOWT/ONLINET, next_phase() and phase_color() functions.
//   Sub-module light_tick_gen: prescaler with enable/clear, outputs 1-cycle tick.
//   Two identical per-road phase/rest registers, in one always block.
// TESTING
//   1. rst, then run 80 clk -> main YELLOWS rest 3 colour 3; sub REDS rest 3.
//   2. Continue 15 clk -> main REDS 19, sub GREENS 16. At 190 clk from reset -> main GREENS 16, sub REDS 19 (38 s period).
//   3. pause at main rest 10 for 37 clk -> states PAUSES, rest 10 held. After release, 10->9 exactly CLOCK_HZ-remaining clocks later.
//   4. online=1 -> states 3, colours 4 (blink period 10 clk if BLINK_EN), times 0.
//      online=0 -> main GREENS/16, sub REDS/19.
//   5. power_en=0 -> colours 0, times 0. power_en=1 -> init phase; first decrement 5 clk later.
//   6. rst mid-yellow with pause=1 -> next cycle init phase; rest=0 init -> advance at first tick.

Source files
------------

// File: rtl/light_pkg.sv
// Shared state/lamp codes, default phase durations and phase helpers for the
// traffic-light controller.
package light_pkg;

    typedef enum logic [2:0] {
        REDS    = 3'd0,
        GREENS  = 3'd1,
        YELLOWS = 3'd2,
        ONLINES = 3'd3,
        PAUSES  = 3'd4
    } light_state_t;

    typedef enum logic [2:0] {
        MODE_RST,
        MODE_OFF,
        MODE_ONLINE,
        MODE_PAUSE,
        MODE_RUN
    } mode_t;

    localparam logic [7:0] DARKL   = 8'd0;
    localparam logic [7:0] REDL    = 8'd1;
    localparam logic [7:0] GREENL  = 8'd2;
    localparam logic [7:0] YELLOWL = 8'd3;
    localparam logic [7:0] ONLINEL = 8'd4;

    localparam int REDT    = 19;
    localparam int GREENT  = 16;
    localparam int YELLOWT = 3;
    localparam int ONLINET = 0;

    // Unknown codes restart the cycle at green.
    function automatic light_state_t next_phase(input light_state_t ph);
        case (ph)
            GREENS:  return YELLOWS;
            YELLOWS: return REDS;
            default: return GREENS;
        endcase
    endfunction

    function automatic logic [7:0] phase_color(input light_state_t ph);
        case (ph)
            REDS:    return REDL;
            GREENS:  return GREENL;
            YELLOWS: return YELLOWL;
            default: return DARKL;
        endcase
    endfunction

endpackage

// File: rtl/light_tick_gen.sv
// Seconds prescaler: counts 0..CLOCK_HZ-1 while enabled and emits a one-cycle
// tick on the last count. Clear wins over enable and suppresses the tick.
module light_tick_gen #(
    parameter int CLOCK_HZ = 5
) (
    input  logic clk,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLOCK_HZ - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clear && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/module_light_ctrl.sv
// Runtime traffic-light controller for main and sub roads with pause and online modes.
// Optional LIGHT_CTRL_BLINK_EN: online colours blink ONLINEL/dark every CLOCK_HZ clocks.
module module_light_ctrl
    import light_pkg::*;
#(
    parameter int CLOCK_HZ = 5,
    parameter int REDT     = 19,
    parameter int GREENT   = 16,
    parameter int YELLOWT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  init_main_state,
    input  logic [2:0]  init_sub_state,
    input  logic [4:0]  init_main_rest,
    input  logic [4:0]  init_sub_rest,
    input  logic        power_en,
    input  logic        pause,
    input  logic        online,
    output logic [2:0]  main_light_state,
    output logic [2:0]  sub_light_state,
    output logic [4:0]  main_rest_time,
    output logic [4:0]  sub_rest_time,
    output logic [15:0] MainTime,
    output logic [15:0] SubTime,
    output logic [7:0]  MainColor,
    output logic [7:0]  SubColor
);

    function automatic logic [4:0] phase_dur(input light_state_t ph);
        case (ph)
            GREENS:  return 5'(GREENT);
            YELLOWS: return 5'(YELLOWT);
            default: return 5'(REDT);
        endcase
    endfunction

    mode_t        mode;
    logic         cnt_en;
    logic         cnt_clr;
    logic         tick;
    logic         run_tick;

    // Index 0 is the main road, index 1 the sub road.
    light_state_t init_phase [2];
    logic [4:0]   init_rest  [2];
    light_state_t phase_q    [2];
    light_state_t phase_d    [2];
    logic [4:0]   rest_q     [2];
    logic [4:0]   rest_d     [2];
    light_state_t st_q       [2];
    light_state_t st_d       [2];
    logic [4:0]   rout_q     [2];
    logic [4:0]   rout_d     [2];
    logic [7:0]   col_q      [2];
    logic [7:0]   col_d      [2];

    assign init_phase[0] = light_state_t'(init_main_state);
    assign init_phase[1] = light_state_t'(init_sub_state);
    assign init_rest[0]  = init_main_rest;
    assign init_rest[1]  = init_sub_rest;

    always_comb begin
        if (rst)            mode = MODE_RST;
        else if (!power_en) mode = MODE_OFF;
        else if (online)    mode = MODE_ONLINE;
        else if (pause)     mode = MODE_PAUSE;
        else                mode = MODE_RUN;
    end

`ifdef LIGHT_CTRL_BLINK_EN
    logic online_q;
    logic blink_q;
    logic blink_d;

    // Prescaler keeps running to pace the blink; leaving online restarts it from 0.
    assign cnt_en  = (mode == MODE_RUN) || (mode == MODE_ONLINE);
    assign cnt_clr = (mode == MODE_RST) || (mode == MODE_OFF) ||
                     (online_q && (mode != MODE_ONLINE));
    assign blink_d = (mode == MODE_ONLINE) ? (blink_q ^ tick) : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            online_q <= 1'b0;
            blink_q  <= 1'b0;
        end else begin
            online_q <= (mode == MODE_ONLINE);
            blink_q  <= blink_d;
        end
    end
`else
    assign cnt_en  = (mode == MODE_RUN);
    assign cnt_clr = (mode == MODE_RST) || (mode == MODE_OFF) || (mode == MODE_ONLINE);
`endif

    light_tick_gen #(
        .CLOCK_HZ (CLOCK_HZ)
    ) u_tick (
        .clk   (clk),
        .clear (cnt_clr),
        .en    (cnt_en),
        .tick  (tick)
    );

    assign run_tick = tick && (mode == MODE_RUN);

    // Next phase/rest per road; rest of 0 is treated like 1 so a bad init still advances.
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            phase_d[r] = phase_q[r];
            rest_d[r]  = rest_q[r];
            case (mode)
                MODE_RST, MODE_OFF, MODE_ONLINE: begin
                    phase_d[r] = init_phase[r];
                    rest_d[r]  = init_rest[r];
                end
                MODE_RUN: begin
                    if (run_tick) begin
                        if (rest_q[r] > 5'd1) begin
                            rest_d[r] = rest_q[r] - 5'd1;
                        end else begin
                            phase_d[r] = next_phase(phase_q[r]);
                            rest_d[r]  = phase_dur(next_phase(phase_q[r]));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs follow the next state so they change on the tick edge itself.
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            st_d[r]   = phase_d[r];
            rout_d[r] = rest_d[r];
            col_d[r]  = phase_color(phase_d[r]);
            case (mode)
                MODE_OFF: begin
                    rout_d[r] = 5'd0;
                    col_d[r]  = DARKL;
                end
                MODE_ONLINE: begin
                    st_d[r]   = ONLINES;
                    rout_d[r] = 5'(ONLINET);
`ifdef LIGHT_CTRL_BLINK_EN
                    col_d[r]  = blink_d ? DARKL : ONLINEL;
`else
                    col_d[r]  = ONLINEL;
`endif
                end
                MODE_PAUSE: begin
                    st_d[r] = PAUSES;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (rst) begin
                phase_q[r] <= init_phase[r];
                rest_q[r]  <= init_rest[r];
                st_q[r]    <= init_phase[r];
                rout_q[r]  <= init_rest[r];
                col_q[r]   <= phase_color(init_phase[r]);
            end else begin
                phase_q[r] <= phase_d[r];
                rest_q[r]  <= rest_d[r];
                st_q[r]    <= st_d[r];
                rout_q[r]  <= rout_d[r];
                col_q[r]   <= col_d[r];
            end
        end
    end

    assign main_light_state = st_q[0];
    assign sub_light_state  = st_q[1];
    assign main_rest_time   = rout_q[0];
    assign sub_rest_time    = rout_q[1];
    assign MainTime         = {11'd0, rout_q[0]};
    assign SubTime          = {11'd0, rout_q[1]};
    assign MainColor        = col_q[0];
    assign SubColor         = col_q[1];

endmodule
